// File: rtl/lcd_cmd_sequencer.sv
// LCD command sequencer: issues the HD44780 power-up init sequence, then
// forwards user character/command bytes to the write-cycle stage one at a time,
// inserting the controller's execution delay after each write.
module lcd_cmd_sequencer #(
  parameter int unsigned POWERUP_CYCLES = 750000,
  parameter int unsigned CMD_WAIT       = 2000,
  parameter int unsigned CLR_WAIT       = 82000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  input  logic       char_is_cmd,
  output logic       char_ready,
  output logic       init_done,
  output logic       wr_enable,
  output logic       reg_sel,
  output logic [7:0] data_out,
  input  logic       wr_finish
);

  localparam logic [2:0] StPwrup  = 3'd0;
  localparam logic [2:0] StIssue  = 3'd1;
  localparam logic [2:0] StWaitwr = 3'd2;
  localparam logic [2:0] StDelay  = 3'd3;
  localparam logic [2:0] StReady  = 3'd4;

  localparam logic [CNT_W-1:0] PwrupLoad = CNT_W'(POWERUP_CYCLES);
  localparam logic [CNT_W-1:0] CmdLoad   = CNT_W'(CMD_WAIT);
  localparam logic [CNT_W-1:0] ClrLoad   = CNT_W'(CLR_WAIT);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             init_done_q, init_done_d;
  logic             reg_sel_q, reg_sel_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             is_clr;
  logic [1:0]       idx_next;

  // Init table: function set, display on, clear, entry mode.
  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    logic [7:0] b;
    unique case (idx)
      2'd0:    b = 8'h38;
      2'd1:    b = 8'h0C;
      2'd2:    b = 8'h01;
      default: b = 8'h06;
    endcase
    return b;
  endfunction

  // Clear display (01h) and return home (02h/03h) need the long execution delay.
  assign is_clr   = ~reg_sel_q && (data_out_q[7:2] == 6'd0) && (data_out_q[1:0] != 2'd0);
  assign idx_next = idx_q + 2'd1;

  // Next-state logic for the sequencer FSM, delay counter and write fields.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    reg_sel_d   = reg_sel_q;
    data_out_d  = data_out_q;
    case (state_q)
      StPwrup: begin
        // Counter holds the remaining cycles including the current one.
        if (cnt_q <= CntOne) begin
          cnt_d      = '0;
          data_out_d = init_byte(idx_q);
          reg_sel_d  = 1'b0;
          state_d    = StIssue;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StIssue: begin
        state_d = StWaitwr;
      end
      StWaitwr: begin
        if (wr_finish) begin
          cnt_d   = is_clr ? ClrLoad : CmdLoad;
          state_d = StDelay;
        end
      end
      StDelay: begin
        if (cnt_q <= CntOne) begin
          cnt_d = '0;
          if (idx_q != 2'd3) begin
            idx_d      = idx_next;
            data_out_d = init_byte(idx_next);
            reg_sel_d  = 1'b0;
            state_d    = StIssue;
          end else begin
            init_done_d = 1'b1;
            state_d     = StReady;
          end
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StReady: begin
        if (char_valid) begin
          data_out_d = char_data;
          reg_sel_d  = ~char_is_cmd;
          state_d    = StIssue;
        end
      end
      default: begin
        state_d = StPwrup;
        cnt_d   = PwrupLoad;
        idx_d   = '0;
      end
    endcase
  end

  // State registers; reset restarts the power-up delay from scratch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StPwrup;
      cnt_q       <= PwrupLoad;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      reg_sel_q   <= 1'b0;
      data_out_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      reg_sel_q   <= reg_sel_d;
      data_out_q  <= data_out_d;
    end
  end

  // Handshake and write strobe decode directly from state.
  always_comb begin
    char_ready = (state_q == StReady);
    wr_enable  = (state_q == StIssue);
  end

  assign init_done = init_done_q;
  assign reg_sel   = reg_sel_q;
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Scoreboard bench for lcd_cmd_sequencer: random user bytes, write-cycle model,
// timing reference computed from the delay rules.
module tb_lcd_cmd_sequencer;

  localparam int PWR  = 10;
  localparam int CMDW = 4;
  localparam int CLRW = 8;
  localparam int BIG  = 1 << 30;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       char_valid = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic       char_is_cmd = 1'b0;
  logic       char_ready;
  logic       init_done;
  logic       wr_enable;
  logic       reg_sel;
  logic [7:0] data_out;
  logic       wr_finish = 1'b0;

  lcd_cmd_sequencer #(
    .POWERUP_CYCLES(PWR),
    .CMD_WAIT      (CMDW),
    .CLR_WAIT      (CLRW),
    .CNT_W         (20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_is_cmd(char_is_cmd),
    .char_ready (char_ready),
    .init_done  (init_done),
    .wr_enable  (wr_enable),
    .reg_sel    (reg_sel),
    .data_out   (data_out),
    .wr_finish  (wr_finish)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] data;
    logic       rs;
    int         v;
  } exp_t;
  exp_t sb[$];

  logic [7:0] init_tab [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Execution delay from the HD44780 rules: clear/home instructions are slow.
  function automatic int exec_wait(input logic [7:0] d, input logic rs);
    if (!rs && d >= 8'd1 && d <= 8'd3) return CLRW;
    return CMDW;
  endfunction

  // Write-cycle model: finish pulse sampled 3 cycles after wr_enable is sampled;
  // sometimes adds a spurious pulse while the sequencer is in its delay.
  int fin_at = -1;
  int spur_at = -1;
  initial forever begin
    @(negedge clk);
    wr_finish = 1'b0;
    if (!rst) begin
      fin_at  = -1;
      spur_at = -1;
    end else begin
      if (cyc == fin_at) begin
        wr_finish = 1'b1;
        fin_at    = -1;
      end else if (cyc == spur_at) begin
        wr_finish = 1'b1;
        spur_at   = -1;
      end
      if (wr_enable) begin
        fin_at  = cyc + 3;
        spur_at = ($urandom_range(1) == 1) ? cyc + 5 : -1;
      end
    end
  end

  // Monitor: reference timeline of when each write must appear and when the
  // sequencer must be ready.
  int  next_ok = BIG;
  int  init_done_at = BIG;
  int  n_init = 0;
  bit  in_reset = 1'b1;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      in_reset     = 1'b1;
      n_init       = 0;
      init_done_at = BIG;
      next_ok      = BIG;
    end else begin
      if (in_reset) begin
        // Reset released mid low phase; one rising edge has passed since.
        in_reset = 1'b0;
        next_ok  = cyc + PWR - 1;
      end
      if (wr_enable) begin
        logic [7:0] ed;
        logic       ers;
        int         t;
        if (n_init < 4) begin
          ed  = init_tab[n_init];
          ers = 1'b0;
          t   = next_ok;
          n_init++;
          check("wr_time", cyc, t);
          check("wr_data", int'(data_out), int'(ed));
          check("wr_rs", int'(reg_sel), int'(ers));
          next_ok = t + 4 + exec_wait(ed, ers);
          if (n_init == 4) init_done_at = next_ok;
        end else if (sb.size() == 0) begin
          check("extra_wr", 1, 0);
        end else begin
          exp_t e;
          e   = sb.pop_front();
          ed  = e.data;
          ers = e.rs;
          t   = ((e.v > next_ok) ? e.v : next_ok) + 1;
          check("wr_time", cyc, t);
          check("wr_data", int'(data_out), int'(ed));
          check("wr_rs", int'(reg_sel), int'(ers));
          next_ok = t + 4 + exec_wait(ed, ers);
        end
      end
      check("char_ready", int'(char_ready), int'(cyc >= init_done_at && cyc >= next_ok));
      check("init_done", int'(init_done), int'(cyc >= init_done_at));
    end
  end

  // Present a byte after an idle gap and hold it until accepted.
  task automatic send(input logic [7:0] d, input logic cmd, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    char_data   = d;
    char_is_cmd = cmd;
    char_valid  = 1'b1;
    sb.push_back('{d, ~cmd, cyc});
    n = 0;
    while (!char_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!char_ready) check("accept_timeout", 0, 1);
    @(negedge clk);
    char_valid  = 1'b0;
    char_data   = 8'($urandom);
    char_is_cmd = 1'($urandom);
  endtask

  task automatic check_reset_outputs();
    check("rst_char_ready", int'(char_ready), 0);
    check("rst_init_done", int'(init_done), 0);
    check("rst_wr_enable", int'(wr_enable), 0);
    check("rst_reg_sel", int'(reg_sel), 0);
    check("rst_data_out", int'(data_out), 0);
  endtask

  task automatic random_bytes(input int count);
    logic [7:0] d;
    for (int i = 0; i < count; i++) begin
      d = ($urandom_range(3) == 0) ? 8'($urandom_range(3)) : 8'($urandom);
      send(d, 1'($urandom_range(1)), $urandom_range(6));
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs();
    #1 rst = 1'b1;
    @(negedge clk);
    // Held during init: must only be taken once the sequencer becomes ready.
    send(8'h41, 1'b0, 0);
    send(8'h01, 1'b1, 2);
    send(8'h01, 1'b0, 0);
    send(8'h02, 1'b1, 1);
    random_bytes(14);
    // Reset while the write-cycle stage is busy (WAITWR).
    send(8'h55, 1'b0, 3);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    send(8'hA5, 1'b0, 0);
    random_bytes(6);
    n = 0;
    while ((sb.size() != 0 || cyc < next_ok) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", int'(sb.size()), 0);
    repeat (12) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lcd_cmd_sequencer.md
Name: lcd_cmd_sequencer

Overview:
Upstream stage of the HD44780 write-cycle block. After power-up it issues the LCD initialisation sequence, then accepts user character and command bytes through a valid/ready handshake. For each byte it drives one write request (wr_enable, reg_sel, data_out), waits for wr_finish, then waits out the controller's execution time before taking the next byte.

Parameters:
POWERUP_CYCLES, 750000, idle cycles after reset before the first command (15 ms at 50 MHz)
CMD_WAIT, 2000, post-write execution delay for normal commands and data (40 us)
CLR_WAIT, 82000, post-write execution delay for clear/home commands (1.64 ms)
CNT_W, 20, delay counter width; must hold the largest of the three delays

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
char_valid  in  1  user byte available
char_data  in  8  user byte
char_is_cmd  in  1  1 = instruction (RS=0), 0 = character data (RS=1)
char_ready  out  1  sequencer can accept a user byte this cycle
init_done  out  1  init sequence complete; sticky until reset
wr_enable  out  1  one-cycle write request to the write-cycle stage
reg_sel  out  1  RS value for the current write
data_out  out  8  LCD data bus value for the current write
wr_finish  in  1  one-cycle pulse from the write-cycle stage: write complete

Behaviour:
- Reset (rst=0, async): state PWRUP, counter loaded with POWERUP_CYCLES, init index 0. All outputs 0: char_ready, init_done, wr_enable, reg_sel, data_out=8'h00. Asserting reset mid-operation aborts everything and restarts the power-up delay.
- States: PWRUP, ISSUE, WAITWR, DELAY, READY.
- PWRUP: counter decrements each cycle. Go to ISSUE on the cycle after the counter reaches 0, so PWRUP lasts exactly POWERUP_CYCLES cycles.
- Init table, indices 0..3, all with RS=0: 8'h38 (function set), 8'h0C (display on), 8'h01 (clear), 8'h06 (entry mode).
- ISSUE: wr_enable=1 for exactly one cycle. Next state is WAITWR.
- WAITWR: wr_enable=0. Wait with no timeout until wr_finish=1 is sampled. On that edge, load the counter and go to DELAY.
  - Load CLR_WAIT if reg_sel=0 and data_out[7:2]=0 and data_out[1:0]!=0 (clear or home).
  - Otherwise load CMD_WAIT.
- DELAY lasts exactly the loaded number of cycles. Exit target:
  - Init index < 3: increment the index, present the next table entry, go to ISSUE.
  - Init index = 3 and init_done=0: set init_done=1, go to READY.
  - Otherwise: go to READY.
- READY: char_ready=1 (combinational from state; 0 in every other state).
  - Accept when char_valid & char_ready at a rising edge.
  - On accept, latch data_out<=char_data and reg_sel<=~char_is_cmd, then go to ISSUE.
  - Latency: wr_enable is high in the cycle immediately after the accept edge.
- reg_sel and data_out are registered. They stay stable from the ISSUE cycle through the end of DELAY, and hold their last value in READY.
- wr_enable is never asserted outside ISSUE, so at most one request is outstanding.
- wr_finish arriving in any state other than WAITWR is ignored.
- char_valid is ignored while char_ready=0. The producer must hold the byte until it is accepted.
- A user clear command (char_is_cmd=1, 8'h01) gets CLR_WAIT. A data byte 8'h01 (char_is_cmd=0) gets CMD_WAIT.
- Counter arithmetic is unsigned CNT_W bits. A delay parameter of 0 is illegal.

Test Plan:
Bench parameters: POWERUP_CYCLES=10, CMD_WAIT=4, CLR_WAIT=8. The write-cycle model pulses wr_finish 3 cycles after sampling wr_enable.
1. Release reset and count cycles -> first wr_enable appears 10 cycles after release with data_out=38h, reg_sel=0. Then 0Ch, 01h and 06h follow. The gap after 01h is 8 delay cycles; the others are 4.
2. After the 4th delay ends -> init_done=1 and char_ready=1. Both stay high with no input.
3. Accept char_data=41h, char_is_cmd=0 -> next cycle wr_enable=1 for one cycle with data_out=41h, reg_sel=1. char_ready=0 for 1+3+4 cycles, then returns to 1.
4. Accept char_is_cmd=1 with 01h -> CLR_WAIT path (8 delay cycles). Repeat with data 01h and char_is_cmd=0 -> CMD_WAIT path (4 delay cycles).
5. Hold char_valid=1 during init and during a user write; also inject a spurious wr_finish in DELAY -> no extra accepts, no extra wr_enable pulses, and delay timing unchanged.
6. Drive rst=0 in the middle of a WAITWR -> all outputs 0 immediately. After release the full 10-cycle power-up delay and the init sequence repeat, with init_done=0 until they complete.
